// File: rtl/snes_multi_if.sv
`default_nettype none
// ============================================================================
//  Module      : snes_multi_if
//  Description : Bus bundle between a multi-pad SNES reader and its host/pads.
//                master = host side (drives start and pad data).
//                slave  = reader side (drives latch/pulse and results).
//  Signals     : start, data[NUM_PLAYERS], latch, pulse, busy, valid,
//                buttons[NUM_PLAYERS*NUM_BITS], present[NUM_PLAYERS],
//                pressed[NUM_PLAYERS*NUM_BITS] (only with SNES_MULTI_EDGE_EN)
//  Macro       : SNES_MULTI_EDGE_EN adds the pressed edge-detect bus.
//  Revision    : 1.0 - initial release
// ============================================================================
interface snes_multi_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_BITS    = 16
);
  logic                            start;
  logic [NUM_PLAYERS-1:0]          data;
  logic                            latch;
  logic                            pulse;
  logic                            busy;
  logic                            valid;
  logic [NUM_PLAYERS*NUM_BITS-1:0] buttons;
  logic [NUM_PLAYERS-1:0]          present;
`ifdef SNES_MULTI_EDGE_EN
  logic [NUM_PLAYERS*NUM_BITS-1:0] pressed;

  modport master (output start, data,
                  input  latch, pulse, busy, valid, buttons, present, pressed);
  modport slave  (input  start, data,
                  output latch, pulse, busy, valid, buttons, present, pressed);
`else
  modport master (output start, data,
                  input  latch, pulse, busy, valid, buttons, present);
  modport slave  (input  start, data,
                  output latch, pulse, busy, valid, buttons, present);
`endif
endinterface
`default_nettype wire

// File: rtl/snes_multi_reader.sv
`default_nettype none
// ============================================================================
//  Module      : snes_multi_reader
//  Description : Polls up to four SNES pads sharing one latch/pulse pair.
//                A start request latches all pads, then NUM_BITS serial bits
//                are sampled per pad (NUM_BITS-1 clock pulses in between).
//                Results are published atomically with a one-cycle valid.
//  Ports       : clk   - system clock (rising edge)
//                rst   - asynchronous active-high reset
//                bus   - snes_multi_if.slave: start, data in; latch, pulse,
//                        busy, valid, buttons, present (pressed) out
//  Macro       : SNES_MULTI_EDGE_EN - adds pressed = new & ~old buttons,
//                updated with each valid strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module snes_multi_reader #(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_BITS    = 16,
  parameter int LATCH_CYC   = 600,
  parameter int HALF_CYC    = 300
) (
  input  wire logic   clk,
  input  wire logic   rst,
  snes_multi_if.slave bus
);
  localparam int c_MAX_CYC = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
  localparam int c_CNT_W   = $clog2(c_MAX_CYC + 1);
  localparam int c_IDX_W   = $clog2(NUM_BITS);
  localparam int c_W       = NUM_PLAYERS * NUM_BITS;

  localparam logic [c_CNT_W-1:0] c_LATCH_LAST = c_CNT_W'(LATCH_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_HALF_LAST  = c_CNT_W'(HALF_CYC - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST   = c_IDX_W'(NUM_BITS - 1);

  localparam logic [2:0] c_IDLE     = 3'd0;
  localparam logic [2:0] c_LATCH    = 3'd1;
  localparam logic [2:0] c_SAMPLE   = 3'd2;
  localparam logic [2:0] c_PULSE_HI = 3'd3;
  localparam logic [2:0] c_PULSE_LO = 3'd4;
  localparam logic [2:0] c_DONE     = 3'd5;

  logic [2:0]             r_state;
  logic [c_CNT_W-1:0]     r_cnt;
  logic [c_IDX_W-1:0]     r_idx;
  logic                   r_latch;
  logic                   r_pulse;
  logic                   r_valid;
  logic [NUM_PLAYERS-1:0] r_sync1;
  logic [NUM_PLAYERS-1:0] r_sync2;
  // r_seen[p] remembers whether any raw sample of pad p was high; a pad that
  // never drove high during the whole frame is treated as unplugged.
  logic [NUM_PLAYERS-1:0] r_seen;
  logic [c_W-1:0]         r_shift;
  logic [c_W-1:0]         r_buttons;
  logic [NUM_PLAYERS-1:0] r_present;
  logic [c_W-1:0]         w_buttons_new;

  // Absent pads report no buttons even though their inverted samples are 1s.
  genvar gp;
  generate
    for (gp = 0; gp < NUM_PLAYERS; gp++) begin : g_player
      assign w_buttons_new[gp*NUM_BITS +: NUM_BITS] =
        r_seen[gp] ? r_shift[gp*NUM_BITS +: NUM_BITS] : '0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.data;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= c_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_latch   <= 1'b0;
      r_pulse   <= 1'b0;
      r_valid   <= 1'b0;
      r_seen    <= '0;
      r_shift   <= '0;
      r_buttons <= '0;
      r_present <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (bus.start) begin
            r_state <= c_LATCH;
            r_latch <= 1'b1;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_seen  <= '0;
          end
        end
        c_LATCH: begin
          if (r_cnt == c_LATCH_LAST) begin
            r_latch <= 1'b0;
            r_cnt   <= '0;
            r_state <= c_SAMPLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        c_SAMPLE: begin
          for (int p = 0; p < NUM_PLAYERS; p++) begin
            r_shift[p*NUM_BITS + int'(r_idx)] <= ~r_sync2[p];
          end
          r_seen <= r_seen | r_sync2;
          if (r_idx == c_IDX_LAST) begin
            r_state <= c_DONE;
          end else begin
            r_state <= c_PULSE_HI;
            r_pulse <= 1'b1;
            r_cnt   <= '0;
          end
        end
        c_PULSE_HI: begin
          if (r_cnt == c_HALF_LAST) begin
            r_pulse <= 1'b0;
            r_cnt   <= '0;
            r_state <= c_PULSE_LO;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        c_PULSE_LO: begin
          if (r_cnt == c_HALF_LAST) begin
            r_cnt   <= '0;
            r_idx   <= r_idx + 1'b1;
            r_state <= c_SAMPLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        c_DONE: begin
          r_buttons <= w_buttons_new;
          r_present <= r_seen;
          r_valid   <= 1'b1;
          r_state   <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
          r_latch <= 1'b0;
          r_pulse <= 1'b0;
        end
      endcase
    end
  end

`ifdef SNES_MULTI_EDGE_EN
  logic [c_W-1:0] r_pressed;

  // r_buttons still holds the previous frame while DONE is active.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pressed <= '0;
    end else if (r_state == c_DONE) begin
      r_pressed <= w_buttons_new & ~r_buttons;
    end
  end

  assign bus.pressed = r_pressed;
`endif

  assign bus.latch   = r_latch;
  assign bus.pulse   = r_pulse;
  assign bus.busy    = (r_state != c_IDLE);
  assign bus.valid   = r_valid;
  assign bus.buttons = r_buttons;
  assign bus.present = r_present;
endmodule
`default_nettype wire

// File: tb/tb_snes_multi_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_snes_multi_reader
//  Description : Directed self-checking bench for snes_multi_reader with a
//                behavioural model of two SNES pads on the shared bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_snes_multi_reader;
  localparam int NP = 2;
  localparam int NB = 16;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  snes_multi_if #(.NUM_PLAYERS(NP), .NUM_BITS(NB)) bus ();

  snes_multi_reader #(
    .NUM_PLAYERS(NP), .NUM_BITS(NB), .LATCH_CYC(600), .HALF_CYC(300)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Pad model: latch reloads the button shift register, each pulse rising
  // edge advances to the next button. Data is active-low; absent pads read 0.
  logic [15:0]   pad_btn    [NP];
  logic          pad_absent [NP];
  int            pad_idx = 0;
  logic [NP-1:0] w_data;

  always @(posedge bus.pulse or posedge bus.latch) begin
    if (bus.latch) pad_idx = 0;
    else           pad_idx = pad_idx + 1;
  end

  always_comb begin
    w_data = '0;
    for (int p = 0; p < NP; p++) begin
      if (pad_absent[p])     w_data[p] = 1'b0;
      else if (pad_idx < NB) w_data[p] = ~pad_btn[p][pad_idx[3:0]];
      else                   w_data[p] = 1'b0;
    end
  end
  assign bus.data = w_data;

  // Issues one start, then watches until valid. cyc = edges after the edge
  // that sampled start (-1 on timeout). A single-cycle start is re-asserted
  // at cycle ignore_at (if >= 0) to probe that busy frames ignore it.
  task automatic run_frame(input int ignore_at, output int cyc, output int latch_cyc,
                           output int rises, output int pulse_cyc, output int overlap);
    logic prev;
    latch_cyc = 0; rises = 0; pulse_cyc = 0; overlap = 0; prev = 1'b0;
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    cyc = 0;
    forever begin
      if (bus.latch) latch_cyc++;
      if (bus.pulse) pulse_cyc++;
      if (bus.pulse && !prev) rises++;
      if (bus.pulse && bus.latch) overlap++;
      prev = bus.pulse;
      bus.start = (cyc == ignore_at);
      @(posedge clk); #1;
      cyc++;
      if (bus.valid) break;
      if (cyc >= 12000) begin cyc = -1; break; end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0;
    for (int p = 0; p < NP; p++) begin pad_btn[p] = 16'h0; pad_absent[p] = 1'b0; end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.latch !== 1'b0) begin failures++; $display("FAIL reset_latch got=%b want=0", bus.latch); end
    checks++; if (bus.pulse !== 1'b0) begin failures++; $display("FAIL reset_pulse got=%b want=0", bus.pulse); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    checks++; if (bus.valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", bus.valid); end
    checks++; if (bus.buttons !== 32'h0) begin failures++; $display("FAIL reset_buttons got=%h want=0", bus.buttons); end
    checks++; if (bus.present !== 2'b00) begin failures++; $display("FAIL reset_present got=%b want=00", bus.present); end
`ifdef SNES_MULTI_EDGE_EN
    checks++; if (bus.pressed !== 32'h0) begin failures++; $display("FAIL reset_pressed got=%h want=0", bus.pressed); end
`endif
    rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_mid_reset();
    int cyc, lc, rs, pc, ov, nvalid;
    pad_btn[0] = 16'h0F00; pad_btn[1] = 16'hA005;
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (5000) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if ({bus.latch, bus.pulse, bus.busy} !== 3'b000) begin
      failures++; $display("FAIL midrst_outputs latch/pulse/busy got=%b want=000", {bus.latch, bus.pulse, bus.busy}); end
    checks++; if (bus.buttons !== 32'h0) begin failures++; $display("FAIL midrst_buttons got=%h want=0", bus.buttons); end
    @(posedge clk); #1 rst = 1'b0;
    nvalid = 0;
    repeat (200) begin @(posedge clk); #1; if (bus.valid || bus.busy) nvalid++; end
    checks++; if (nvalid !== 0) begin failures++; $display("FAIL midrst_no_valid got=%0d want=0", nvalid); end
    run_frame(-1, cyc, lc, rs, pc, ov);
    checks++; if (cyc !== 9617) begin failures++; $display("FAIL midrst_frame_len got=%0d want=9617", cyc); end
    checks++; if (bus.buttons !== 32'hA005_0F00) begin failures++; $display("FAIL midrst_buttons2 got=%h want=a0050f00", bus.buttons); end
    checks++; if (bus.present !== 2'b11) begin failures++; $display("FAIL midrst_present got=%b want=11", bus.present); end
  endtask

  task automatic test_basic_frame();
    int cyc, lc, rs, pc, ov;
    pad_btn[0] = 16'h0081; pad_btn[1] = 16'h0000;  // pad0: B + Right
    run_frame(-1, cyc, lc, rs, pc, ov);
    checks++; if (cyc !== 9617) begin failures++; $display("FAIL basic_frame_len got=%0d want=9617", cyc); end
    checks++; if (lc !== 600) begin failures++; $display("FAIL basic_latch_cycles got=%0d want=600", lc); end
    checks++; if (rs !== 15) begin failures++; $display("FAIL basic_pulse_count got=%0d want=15", rs); end
    checks++; if (pc !== 4500) begin failures++; $display("FAIL basic_pulse_high_cycles got=%0d want=4500", pc); end
    checks++; if (ov !== 0) begin failures++; $display("FAIL basic_latch_pulse_overlap got=%0d want=0", ov); end
    checks++; if (bus.buttons[15:0] !== 16'h0081) begin failures++; $display("FAIL basic_pad0 got=%h want=0081", bus.buttons[15:0]); end
    checks++; if (bus.buttons[31:16] !== 16'h0000) begin failures++; $display("FAIL basic_pad1 got=%h want=0000", bus.buttons[31:16]); end
    checks++; if (bus.present !== 2'b11) begin failures++; $display("FAIL basic_present got=%b want=11", bus.present); end
    @(posedge clk); #1;
    checks++; if (bus.valid !== 1'b0) begin failures++; $display("FAIL basic_valid_width got=%b want=0", bus.valid); end
    checks++; if (bus.buttons[15:0] !== 16'h0081) begin failures++; $display("FAIL basic_hold got=%h want=0081", bus.buttons[15:0]); end
  endtask

  task automatic test_start_ignored();
    int cyc, lc, rs, pc, ov, extra;
    pad_btn[0] = 16'h8002; pad_btn[1] = 16'hFFFF; pad_absent[1] = 1'b1;
    run_frame(3000, cyc, lc, rs, pc, ov);
    checks++; if (cyc !== 9617) begin failures++; $display("FAIL ignore_frame_len got=%0d want=9617", cyc); end
    checks++; if (bus.buttons !== 32'h0000_8002) begin failures++; $display("FAIL ignore_buttons got=%h want=00008002", bus.buttons); end
    checks++; if (bus.present !== 2'b01) begin failures++; $display("FAIL absent_present got=%b want=01", bus.present); end
    extra = 0;
    repeat (50) begin @(posedge clk); #1; if (bus.busy || bus.valid) extra++; end
    checks++; if (extra !== 0) begin failures++; $display("FAIL ignore_second_frame got=%0d want=0", extra); end
    pad_absent[1] = 1'b0;
  endtask

  task automatic test_back_to_back();
    int cyc, nv, busy_lo, latch_rise;
    int vt [3];
    logic prev_latch;
    pad_btn[0] = 16'h0410; pad_btn[1] = 16'h0003;
    nv = 0; busy_lo = 0; latch_rise = 0; prev_latch = 1'b0;
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    while (nv < 3 && cyc < 30000) begin
      if (bus.latch && !prev_latch) latch_rise++;
      prev_latch = bus.latch;
      @(posedge clk); #1;
      cyc++;
      if (!bus.busy) busy_lo++;
      if (bus.valid) begin vt[nv] = cyc; nv++; end
    end
    bus.start = 1'b0;
    checks++; if (nv !== 3) begin failures++; $display("FAIL b2b_valid_count got=%0d want=3", nv); end
    if (nv == 3) begin
      checks++; if (vt[0] !== 9617) begin failures++; $display("FAIL b2b_first got=%0d want=9617", vt[0]); end
      checks++; if (vt[1] - vt[0] !== 9618) begin failures++; $display("FAIL b2b_gap1 got=%0d want=9618", vt[1] - vt[0]); end
      checks++; if (vt[2] - vt[1] !== 9618) begin failures++; $display("FAIL b2b_gap2 got=%0d want=9618", vt[2] - vt[1]); end
    end
    checks++; if (busy_lo !== 3) begin failures++; $display("FAIL b2b_busy_low got=%0d want=3", busy_lo); end
    checks++; if (latch_rise !== 3) begin failures++; $display("FAIL b2b_latches got=%0d want=3", latch_rise); end
    checks++; if (bus.buttons !== 32'h0003_0410) begin failures++; $display("FAIL b2b_buttons got=%h want=00030410", bus.buttons); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL b2b_stop got=%b want=0", bus.busy); end
  endtask

`ifdef SNES_MULTI_EDGE_EN
  task automatic test_edge();
    int cyc, lc, rs, pc, ov;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    pad_btn[0] = 16'h0001; pad_btn[1] = 16'h0000;  // B
    run_frame(-1, cyc, lc, rs, pc, ov);
    checks++; if (bus.pressed[15:0] !== 16'h0001) begin failures++; $display("FAIL edge_frame1 got=%h want=0001", bus.pressed[15:0]); end
    pad_btn[0] = 16'h0101;                         // B + A: only A is new
    run_frame(-1, cyc, lc, rs, pc, ov);
    checks++; if (bus.pressed[15:0] !== 16'h0100) begin failures++; $display("FAIL edge_frame2 got=%h want=0100", bus.pressed[15:0]); end
    checks++; if (bus.pressed[31:16] !== 16'h0000) begin failures++; $display("FAIL edge_pad1 got=%h want=0000", bus.pressed[31:16]); end
  endtask
`endif

  initial begin
    test_reset();
    test_mid_reset();
    test_basic_frame();
    test_start_ignored();
    test_back_to_back();
`ifdef SNES_MULTI_EDGE_EN
    test_edge();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
